// File: rtl/giraffe_cap_pkg.sv
// Shared types and constants for the Giraffe SAR capture controller.
package giraffe_cap_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = BYTE_W - 2;

  localparam logic [1:0] TAG_MAIN = 2'b11;
  localparam logic [1:0] TAG_SUB  = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    SAMPLE,
    SEND,
    ERR
  } cap_state_e;

  // One buffer entry: tag in the top two bits, zero-padded sub-ADC word below
  typedef struct packed {
    logic [1:0]        tag;
    logic [WORD_W-1:0] word;
  } cap_byte_t;

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Byte stream handshake from the capture controller to uart_tx.
interface adc_capture_ctrl_if;
  import giraffe_cap_pkg::*;

  logic              uart_wreq;
  logic [BYTE_W-1:0] uart_wdata;
  logic              uart_rdy;

  modport master (output uart_wreq, output uart_wdata, input uart_rdy);
  modport slave  (input uart_wreq, input uart_wdata, output uart_rdy);
endinterface

// File: rtl/adc_ack_sync.sv
// Brings the chip's async acks and data into clk_50M and turns ack rising edges into capture strobes.
module adc_ack_sync #(
  parameter int unsigned N_BIT = 6
) (
  input  logic             clk_50M,
  input  logic             nrst,
  input  logic             adc_ack,
  input  logic             adc_ack_sub,
  input  logic [N_BIT-1:0] dout_adc,
  output logic             strobe,
  output logic             is_main,
  output logic [N_BIT-1:0] data
);

  logic [1:0]       ack_sr;
  logic [1:0]       sub_sr;
  logic [N_BIT-1:0] dout_s1;
  logic [N_BIT-1:0] dout_s2;
  logic             any_q;
  logic             any_c;

  // Data runs through the same two stages as the acks so both are sampled at one instant
  assign any_c = ack_sr[1] | sub_sr[1];

  always_ff @(posedge clk_50M or negedge nrst) begin
    if (!nrst) begin
      ack_sr  <= '0;
      sub_sr  <= '0;
      dout_s1 <= '0;
      dout_s2 <= '0;
      any_q   <= 1'b0;
      strobe  <= 1'b0;
      is_main <= 1'b0;
      data    <= '0;
    end else begin
      ack_sr  <= {ack_sr[0], adc_ack};
      sub_sr  <= {sub_sr[0], adc_ack_sub};
      dout_s1 <= dout_adc;
      dout_s2 <= dout_s1;
      any_q   <= any_c;
      strobe  <= any_c & ~any_q;
      is_main <= ack_sr[1];
      data    <= dout_s2;
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Giraffe SAR capture controller: chip reset, conversion enables, tagged capture, UART readout.
// Define CAPTURE_CHECKSUM_EN to append an XOR checksum byte after the data bytes.
module adc_capture_ctrl
  import giraffe_cap_pkg::*;
#(
  parameter int unsigned N_BIT         = 6,
  parameter int unsigned WORDS_PER_SMP = 4,
  parameter int unsigned NUM_SAMPLES   = 32768,
  parameter int unsigned ENA_PERIOD    = 25,
  parameter int unsigned RESET_CYCLES  = 1000,
  parameter int unsigned ACK_TIMEOUT   = 4096
) (
  input  logic                   clk_50M,
  input  logic                   nrst,
  input  logic                   start,
  input  logic                   adc_ack,
  input  logic                   adc_ack_sub,
  input  logic [N_BIT-1:0]       dout_adc,
  output logic                   rstn_adc,
  output logic                   adc_ena,
  adc_capture_ctrl_if.master     uart,
  output logic                   busy,
  output logic                   done,
  output logic                   err_timeout,
  output logic [17:0]            cnt_rx
);

  localparam int unsigned DEPTH = NUM_SAMPLES * WORDS_PER_SMP;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned RW    = $clog2(RESET_CYCLES + 1);
  localparam int unsigned DW    = $clog2(ENA_PERIOD + 1);
  localparam int unsigned EW    = $clog2(NUM_SAMPLES + 1);
  localparam int unsigned TW    = $clog2(ACK_TIMEOUT + 1);
`ifdef CAPTURE_CHECKSUM_EN
  localparam int unsigned N_TX  = DEPTH + 1;
`else
  localparam int unsigned N_TX  = DEPTH;
`endif

  cap_state_e        state_q, state_d;
  logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [DW-1:0]     div_q, div_d;
  logic [EW-1:0]     ena_cnt_q, ena_cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     tx_q, tx_d;
  logic              rstn_q, rstn_d;
  logic              ena_q, ena_d;
  logic              wreq_q, wreq_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [BYTE_W-1:0] wdata_q;
  logic              we_c;
  logic              rd_en_c;
`ifdef CAPTURE_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;
`endif

  logic              sync_strobe;
  logic              sync_main;
  logic [N_BIT-1:0]  sync_data;
  cap_byte_t         wbyte_c;

  logic [BYTE_W-1:0] mem [DEPTH];

  adc_ack_sync #(.N_BIT(N_BIT)) u_ack_sync (
    .clk_50M     (clk_50M),
    .nrst        (nrst),
    .adc_ack     (adc_ack),
    .adc_ack_sub (adc_ack_sub),
    .dout_adc    (dout_adc),
    .strobe      (sync_strobe),
    .is_main     (sync_main),
    .data        (sync_data)
  );

  assign wbyte_c.tag  = sync_main ? TAG_MAIN : TAG_SUB;
  assign wbyte_c.word = WORD_W'(sync_data);

  always_ff @(posedge clk_50M or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      rst_cnt_q <= '0;
      div_q     <= '0;
      ena_cnt_q <= '0;
      tmo_q     <= '0;
      cnt_q     <= '0;
      tx_q      <= '0;
      rstn_q    <= 1'b1;
      ena_q     <= 1'b0;
      wreq_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef CAPTURE_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      div_q     <= div_d;
      ena_cnt_q <= ena_cnt_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
      tx_q      <= tx_d;
      rstn_q    <= rstn_d;
      ena_q     <= ena_d;
      wreq_q    <= wreq_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
`ifdef CAPTURE_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    div_d     = div_q;
    ena_cnt_d = ena_cnt_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    tx_d      = tx_q;
    rstn_d    = rstn_q;
    ena_d     = 1'b0;
    wreq_d    = wreq_q;
    done_d    = 1'b0;
    err_d     = err_q;
    we_c      = 1'b0;
    rd_en_c   = 1'b0;
`ifdef CAPTURE_CHECKSUM_EN
    csum_d    = csum_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RST;
          rst_cnt_d = '0;
          div_d     = '0;
          ena_cnt_d = '0;
          tmo_d     = '0;
          cnt_d     = '0;
          tx_d      = '0;
          err_d     = 1'b0;
          rstn_d    = 1'b0;
`ifdef CAPTURE_CHECKSUM_EN
          csum_d    = '0;
`endif
        end
      end

      RST: begin
        if (rst_cnt_q == RW'(RESET_CYCLES - 1)) begin
          state_d = SAMPLE;
          rstn_d  = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end

      SAMPLE: begin
        // Timeout window restarts on every enable and every strobe
        tmo_d = tmo_q + TW'(1);
        if (ena_cnt_q < EW'(NUM_SAMPLES)) begin
          if (div_q == DW'(ENA_PERIOD - 1)) begin
            div_d     = '0;
            ena_d     = 1'b1;
            ena_cnt_d = ena_cnt_q + EW'(1);
            tmo_d     = '0;
          end else begin
            div_d = div_q + DW'(1);
          end
        end
        if (sync_strobe) begin
          tmo_d = '0;
          if (cnt_q < CW'(DEPTH)) begin
            we_c  = 1'b1;
            cnt_d = cnt_q + CW'(1);
`ifdef CAPTURE_CHECKSUM_EN
            csum_d = csum_q ^ wbyte_c;
`endif
          end
        end
        if (ena_cnt_q == EW'(NUM_SAMPLES) && cnt_q == CW'(DEPTH)) begin
          state_d = SEND;
        end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
          state_d = ERR;
          err_d   = 1'b1;
        end
      end

      SEND: begin
        // Load cycle between bytes covers the RAM read latency
        if (wreq_q) begin
          if (uart.uart_rdy) begin
            wreq_d = 1'b0;
            if (tx_q == CW'(N_TX - 1)) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              tx_d = tx_q + CW'(1);
            end
          end
        end else begin
          wreq_d  = 1'b1;
          rd_en_c = 1'b1;
        end
      end

      ERR: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_50M) begin
    if (we_c) mem[cnt_q[AW-1:0]] <= wbyte_c;
  end

  always_ff @(posedge clk_50M or negedge nrst) begin
    if (!nrst) begin
      wdata_q <= '0;
    end else if (rd_en_c) begin
`ifdef CAPTURE_CHECKSUM_EN
      wdata_q <= (tx_q == CW'(DEPTH)) ? csum_q : mem[tx_q[AW-1:0]];
`else
      wdata_q <= mem[tx_q[AW-1:0]];
`endif
    end
  end

  assign rstn_adc        = rstn_q;
  assign adc_ena         = ena_q;
  assign uart.uart_wreq  = wreq_q;
  assign uart.uart_wdata = wdata_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err_timeout     = err_q;
  assign cnt_rx          = 18'(cnt_q);

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: table of capture scenarios with a chip model, random UART back-pressure
// and a byte-stream reference built from the words the chip model emitted.
module tb_adc_capture_ctrl;

  localparam int NUM   = 8;
  localparam int WPS   = 4;
  localparam int EP    = 25;
  localparam int RC    = 10;
  localparam int TMO   = 4096;
  localparam int DEPTH = NUM * WPS;
`ifdef CAPTURE_CHECKSUM_EN
  localparam int NTX   = DEPTH + 1;
`else
  localparam int NTX   = DEPTH;
`endif

  logic        clk_50M;
  logic        nrst;
  logic        start;
  logic        adc_ack;
  logic        adc_ack_sub;
  logic [5:0]  dout_adc;
  logic        rstn_adc;
  logic        adc_ena;
  logic        busy;
  logic        done;
  logic        err_timeout;
  logic [17:0] cnt_rx;

  adc_capture_ctrl_if u_if ();

  adc_capture_ctrl #(
    .N_BIT(6), .WORDS_PER_SMP(WPS), .NUM_SAMPLES(NUM),
    .ENA_PERIOD(EP), .RESET_CYCLES(RC), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk_50M     (clk_50M),
    .nrst        (nrst),
    .start       (start),
    .adc_ack     (adc_ack),
    .adc_ack_sub (adc_ack_sub),
    .dout_adc    (dout_adc),
    .rstn_adc    (rstn_adc),
    .adc_ena     (adc_ena),
    .uart        (u_if.master),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .cnt_rx      (cnt_rx)
  );

  typedef struct {
    int stop;       // samples the chip answers
    bit rand_data;
    bit rdy_rand;
    int stall;      // rdy low cycles after byte 10
    bit extra;      // spurious acks after the last word
    bit start_mid;  // extra start pulse during SAMPLE
    bit exp_err;
    int exp_done;
    int exp_bytes;
    int exp_cnt;
  } vec_t;

  vec_t tbl[5];

  int n_total = 0;
  int n_bad   = 0;

  int chip_stop  = 0;
  bit chip_rand  = 0;
  bit chip_extra = 0;
  int chip_smp   = 0;
  int smp_data [NUM];

  bit rdy_rand   = 0;
  int stall_len  = 0;
  bit stall_req  = 0;
  int stall_left = 0;

  int  cyc = 0;
  int  rst_low = 0;
  int  rstn_rise = 0;
  bit  rstn_prev = 1;
  int  done_cnt = 0;
  int  err_rise = 0;
  bit  err_prev = 0;
  bit  hold_prev = 0;
  bit  xfer_prev = 0;
  logic [7:0] hold_data = '0;
  int  ena_cyc[$];
  int  rx_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;

  // Observation at the falling edge: timings, handshake rules and received bytes
  always @(negedge clk_50M) begin
    cyc++;
    if (!rstn_adc) rst_low++;
    if (rstn_adc && !rstn_prev) rstn_rise = cyc;
    rstn_prev = rstn_adc;
    if (adc_ena) ena_cyc.push_back(cyc);
    if (done) done_cnt++;
    if (err_timeout && !err_prev) err_rise = cyc;
    err_prev = err_timeout;
    if (!nrst) begin
      hold_prev = 0;
      xfer_prev = 0;
    end else begin
      if (hold_prev) begin
        chk("wreq_held", 64'(u_if.uart_wreq), 1);
        chk("wdata_stable", 64'(u_if.uart_wdata), 64'(hold_data));
      end
      if (xfer_prev) chk("wreq_gap", 64'(u_if.uart_wreq), 0);
      if (u_if.uart_wreq && u_if.uart_rdy) begin
        rx_q.push_back(int'(u_if.uart_wdata));
        if (stall_req && rx_q.size() == 10) begin
          stall_left = stall_len;
          stall_req  = 0;
        end
      end
      hold_prev = u_if.uart_wreq && !u_if.uart_rdy;
      hold_data = u_if.uart_wdata;
      xfer_prev = u_if.uart_wreq && u_if.uart_rdy;
    end
  end

  // UART receiver readiness
  initial begin
    u_if.uart_rdy = 1'b1;
    forever begin
      @(posedge clk_50M);
      #1;
      if (stall_left > 0) begin
        u_if.uart_rdy = 1'b0;
        stall_left--;
      end else if (rdy_rand) begin
        u_if.uart_rdy = ($urandom_range(0, 3) != 0);
      end else begin
        u_if.uart_rdy = 1'b1;
      end
    end
  end

  // Chip model: three sub words then one main word per enable
  initial begin
    adc_ack = 1'b0;
    adc_ack_sub = 1'b0;
    dout_adc = '0;
    forever begin
      @(negedge clk_50M);
      if (adc_ena === 1'b1) begin
        automatic int idx = chip_smp;
        chip_smp++;
        if (idx < chip_stop) begin
          automatic int d = chip_rand ? int'($urandom_range(0, 63)) : idx;
          smp_data[idx] = d;
          for (int w = 0; w < WPS; w++) begin
            @(posedge clk_50M); #3;
            dout_adc = 6'(d);
            @(posedge clk_50M); #3;
            if (w == WPS - 1) adc_ack = 1'b1;
            else adc_ack_sub = 1'b1;
            repeat (2) @(posedge clk_50M);
            #3;
            adc_ack = 1'b0;
            adc_ack_sub = 1'b0;
          end
          if (chip_extra && idx == NUM - 1) begin
            for (int e = 0; e < 2; e++) begin
              @(posedge clk_50M); #3;
              adc_ack_sub = 1'b1;
              @(posedge clk_50M); #3;
              adc_ack_sub = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic run_capture(input vec_t r, input string tag);
    int exp_q[$];
    int xs;
    bit idle_seen;
    chip_stop  = r.stop;
    chip_rand  = r.rand_data;
    chip_extra = r.extra;
    chip_smp   = 0;
    rdy_rand   = r.rdy_rand;
    stall_len  = r.stall;
    stall_req  = (r.stall > 0);
    rx_q.delete();
    ena_cyc.delete();
    done_cnt = 0;
    rst_low  = 0;
    err_rise = 0;

    @(negedge clk_50M); start = 1'b1;
    @(negedge clk_50M); start = 1'b0;
    chk({tag, "_busy_after_start"}, 64'(busy), 1);
    chk({tag, "_err_cleared"}, 64'(err_timeout), 0);

    if (r.start_mid) begin
      repeat (60) @(negedge clk_50M);
      start = 1'b1;
      @(negedge clk_50M); start = 1'b0;
    end

    idle_seen = 0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk_50M);
      if (!busy) begin
        idle_seen = 1;
        break;
      end
    end
    if (!idle_seen) chk({tag, "_busy_timeout"}, 1, 0);
    repeat (20) @(negedge clk_50M);

    chk({tag, "_rstn_low_cycles"}, rst_low, RC);
    chk({tag, "_ena_pulses"}, ena_cyc.size(), NUM);
    if (ena_cyc.size() > 0) begin
      chk({tag, "_first_ena_delay"}, ena_cyc[0] - rstn_rise, EP);
      for (int k = 1; k < ena_cyc.size(); k++)
        chk({tag, "_ena_period"}, ena_cyc[k] - ena_cyc[k-1], EP);
    end
    chk({tag, "_err_timeout"}, 64'(err_timeout), 64'(r.exp_err));
    chk({tag, "_done_pulses"}, done_cnt, r.exp_done);
    chk({tag, "_byte_count"}, rx_q.size(), r.exp_bytes);
    chk({tag, "_cnt_rx"}, 64'(cnt_rx), r.exp_cnt);
    if (r.exp_err && ena_cyc.size() > 0)
      chk({tag, "_timeout_latency"}, err_rise - ena_cyc[ena_cyc.size()-1], TMO);

    // Expected stream: per sample, sub-tagged words then one main-tagged word
    if (!r.exp_err) begin
      xs = 0;
      for (int s = 0; s < NUM; s++)
        for (int w = 0; w < WPS; w++) begin
          automatic int b = ((w == WPS - 1) ? 'hC0 : 'h00) | smp_data[s];
          exp_q.push_back(b);
          xs = xs ^ b;
        end
`ifdef CAPTURE_CHECKSUM_EN
      exp_q.push_back(xs);
`endif
      for (int i = 0; i < exp_q.size(); i++)
        chk({tag, "_byte"}, (i < rx_q.size()) ? rx_q[i] : -1, exp_q[i]);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rstn_adc"}, 64'(rstn_adc), 1);
    chk({tag, "_adc_ena"}, 64'(adc_ena), 0);
    chk({tag, "_wreq"}, 64'(u_if.uart_wreq), 0);
    chk({tag, "_wdata"}, 64'(u_if.uart_wdata), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_err"}, 64'(err_timeout), 0);
    chk({tag, "_cnt_rx"}, 64'(cnt_rx), 0);
  endtask

  initial begin
    bit seen;
    nrst  = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk_50M);
    chk_reset_vals("por");
    @(posedge clk_50M); #2;
    nrst = 1'b1;

    //            stop rand rdyr stall extra smid  err done bytes cnt
    tbl[0] = '{8, 1'b0, 1'b0, 0,   1'b0, 1'b0, 1'b0, 1, NTX, DEPTH};
    tbl[1] = '{8, 1'b0, 1'b1, 100, 1'b0, 1'b0, 1'b0, 1, NTX, DEPTH};
    tbl[2] = '{3, 1'b0, 1'b0, 0,   1'b0, 1'b0, 1'b1, 0, 0,   3 * WPS};
    tbl[3] = '{8, 1'b0, 1'b1, 0,   1'b1, 1'b1, 1'b0, 1, NTX, DEPTH};
    tbl[4] = '{8, 1'b1, 1'b1, 0,   1'b0, 1'b0, 1'b0, 1, NTX, DEPTH};

    for (int i = 0; i < 5; i++) run_capture(tbl[i], $sformatf("v%0d", i));

    // Reset asserted while bytes are streaming, then a fresh capture
    chip_stop = NUM; chip_rand = 0; chip_extra = 0; chip_smp = 0;
    rdy_rand = 0; stall_req = 0;
    rx_q.delete();
    @(negedge clk_50M); start = 1'b1;
    @(negedge clk_50M); start = 1'b0;
    seen = 0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk_50M);
      if (rx_q.size() >= 5) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk("abort_reach_send_timeout", 1, 0);
    @(posedge clk_50M); #2;
    nrst = 1'b0;
    @(negedge clk_50M);
    chk_reset_vals("abort");
    repeat (2) @(negedge clk_50M);
    @(posedge clk_50M); #2;
    nrst = 1'b1;
    run_capture(tbl[0], "post_abort");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
